// File: rtl/prog_loader.sv
// Boot-time program loader: receives a word count and little-endian words over
// a byte stream, writes them to block RAM from address 0, then hands the port to the core.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              core_memwe,
    input  logic [ADDR_W-1:0] core_memaddr,
    input  logic [31:0]       core_memdin,
    output logic              memwe,
    output logic [ADDR_W-1:0] memaddr,
    output logic [31:0]       memdin,
    output logic              core_rstn,
    output logic              loading
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_LEN,
        S_BYTE,
        S_WRITE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        bidx_q;
    logic [31:0]       word_q;
    logic              core_rstn_q;

    logic              rx_fire;
    logic              run;
    logic [8:0]        len_byte;

    assign run      = (state_q == S_RUN);
    assign rx_ready = !rst && ((state_q == S_LEN) || (state_q == S_BYTE));
    assign rx_fire  = rx_valid && rx_ready;
    // A count byte of zero encodes the full 256-word load.
    assign len_byte = {rx_data == 8'd0, rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN;
            waddr_q     <= '0;
            cnt_q       <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            core_rstn_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_LEN: begin
                    if (rx_fire) begin
                        cnt_q   <= CW'(len_byte);
                        bidx_q  <= '0;
                        state_q <= S_BYTE;
                    end
                end
                S_BYTE: begin
                    if (rx_fire) begin
                        word_q[{bidx_q, 3'b000} +: 8] <= rx_data;
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    waddr_q <= waddr_q + ADDR_W'(1);
                    cnt_q   <= cnt_q - CW'(1);
                    bidx_q  <= '0;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_BYTE;
                    end
                end
                S_RELEASE: begin
                    core_rstn_q <= 1'b1;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_LEN;
                end
            endcase
        end
    end

    // Reset forces the RAM port quiet regardless of the registered state.
    assign memwe   = !rst && (run ? core_memwe : (state_q == S_WRITE));
    assign memaddr = rst ? '0 : (run ? core_memaddr : waddr_q);
    assign memdin  = rst ? '0 : (run ? core_memdin : word_q);

    assign core_rstn = core_rstn_q;
    assign loading   = rst || !run;

endmodule
